// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch engine.
// Walks a word-addressed PC through a four-state request/response/hold
// cycle, presents each fetched word to decode with a valid/ready
// handshake, and redirects on a branch request from any state.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  output logic [31:0] ADDR,
  output logic [1:0]  RW,
  output logic        RAM_EN,
  input  logic [31:0] FETCH,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic [15:0] FETCH_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [15:0] fetch_cnt;
  logic        handshake;
  logic        capture;

  // Decode has taken the held instruction this edge.
  assign handshake = INSTR_VALID & INSTR_READY;

  // The memory word on FETCH belongs to the request issued last cycle.
  // A redirect on the same edge makes that word stale, so it is dropped.
  assign capture = (state == RESP) & ~BR_TAKEN;

  // The memory port only ever reads, and the address is always the PC.
  assign RW        = 2'b01;
  assign ADDR      = pc;
  assign FETCH_CNT = fetch_cnt;

  // Control FSM; RAM_EN is registered so it is high exactly while in REQ.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      RAM_EN <= 1'b0;
    end else if (BR_TAKEN) begin
      // A redirect restarts the fetch sequence from any state.
      // NOTE: non-blocking assignments here so every register in the design
      // sees the pre-edge value of state/pc, independent of block order.
      state  <= ENABLE ? REQ : IDLE;
      RAM_EN <= ENABLE;
    end else begin
      case (state)
        IDLE: begin
          state  <= ENABLE ? REQ : IDLE;
          RAM_EN <= ENABLE;
        end
        REQ: begin
          state  <= RESP;
          RAM_EN <= 1'b0;
        end
        RESP: begin
          state  <= HOLD;
          RAM_EN <= 1'b0;
        end
        HOLD: begin
          // ENABLE is only consulted when leaving HOLD, never to abort it.
          if (handshake) begin
            state  <= ENABLE ? REQ : IDLE;
            RAM_EN <= ENABLE;
          end else begin
            state  <= HOLD;
            RAM_EN <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          RAM_EN <= 1'b0;
        end
      endcase
    end
  end

  // Program counter: redirect wins, otherwise advance once per capture.
  // The 32-bit add wraps 32'hFFFFFFFF to 0 naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= RESET_PC;
    end else if (BR_TAKEN) begin
      pc <= BR_TARGET;
    end else if (capture) begin
      pc <= pc + 32'd1;
    end
  end

  // Instruction holding register and the PC it was fetched from.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: these are plain data registers, but decode may observe them
      // right after reset, so they are cleared to a defined zero.
      INSTR    <= '0;
      INSTR_PC <= '0;
    end else if (capture) begin
      INSTR    <= FETCH;
      INSTR_PC <= pc;
    end
  end

  // Valid flag: set on capture, cleared only by handshake or redirect.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      INSTR_VALID <= 1'b0;
    end else if (BR_TAKEN) begin
      INSTR_VALID <= 1'b0;
    end else if (capture) begin
      INSTR_VALID <= 1'b1;
    end else if (handshake) begin
      INSTR_VALID <= 1'b0;
    end
  end

  // Delivered-instruction counter; wraps 16'hFFFF to 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_cnt <= '0;
    end else if (capture) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with a synchronous read
// memory model. A second instance starts at the top of the address space
// to exercise PC wrap-around.

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        instr_ready;
  logic        br_taken;
  logic [31:0] br_target;

  logic [31:0] addr,  addr2;
  logic [1:0]  rw,    rw2;
  logic        ram_en, ram_en2;
  logic [31:0] fetch, fetch2;
  logic [31:0] instr, instr2;
  logic [31:0] instr_pc, instr_pc2;
  logic        instr_valid, instr_valid2;
  logic [15:0] fetch_cnt, fetch_cnt2;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .ADDR(addr), .RW(rw),
    .RAM_EN(ram_en), .FETCH(fetch), .INSTR(instr), .INSTR_PC(instr_pc),
    .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
    .BR_TAKEN(br_taken), .BR_TARGET(br_target), .FETCH_CNT(fetch_cnt)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
    .CLK(clk), .RST_N(rst_n), .ENABLE(enable), .ADDR(addr2), .RW(rw2),
    .RAM_EN(ram_en2), .FETCH(fetch2), .INSTR(instr2), .INSTR_PC(instr_pc2),
    .INSTR_VALID(instr_valid2), .INSTR_READY(instr_ready),
    .BR_TAKEN(br_taken), .BR_TARGET(br_target), .FETCH_CNT(fetch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word at address a is 32'hA0A0_0000 + a (A0, A1, ...).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0A0_0000 + a;
  endfunction

  // Synchronous read memory: data appears the cycle after RAM_EN.
  always @(posedge clk) begin
    if (ram_en)  fetch  <= mem_word(addr);
    if (ram_en2) fetch2 <= mem_word(addr2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_target   = 32'd0;
    fetch       = 32'd0;
    fetch2      = 32'd0;
    tick();
    tick();

    // Reset state.
    check("rst_addr",   addr,        32'd0);
    check("rst_ram_en", ram_en,      32'd0);
    check("rst_rw",     rw,          32'd1);
    check("rst_instr",  instr,       32'd0);
    check("rst_ipc",    instr_pc,    32'd0);
    check("rst_valid",  instr_valid, 32'd0);
    check("rst_cnt",    fetch_cnt,   32'd0);
    check("rst_addr2",  addr2,       32'hFFFF_FFFF);

    // Streaming fetch with decode always ready: REQ, RESP, HOLD per word.
    rst_n       = 1'b1;
    enable      = 1'b1;
    instr_ready = 1'b1;
    tick();
    check("req0_en",   ram_en, 32'd1);
    check("req0_addr", addr,   32'd0);
    tick();
    check("resp0_en",    ram_en,      32'd0);
    check("resp0_valid", instr_valid, 32'd0);
    tick();
    check("hold0_instr", instr,       32'hA0A0_0000);
    check("hold0_ipc",   instr_pc,    32'd0);
    check("hold0_valid", instr_valid, 32'd1);
    check("hold0_cnt",   fetch_cnt,   32'd1);
    check("hold0_ipc2",  instr_pc2,   32'hFFFF_FFFF);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("reqn_en",   ram_en, 32'd1);
      check("reqn_addr", addr,   i);
      tick();
      tick();
      check("holdn_instr", instr,     32'hA0A0_0000 + i);
      check("holdn_ipc",   instr_pc,  i);
      check("holdn_cnt",   fetch_cnt, i + 1);
      if (i == 1) check("wrap_ipc2", instr_pc2, 32'd0);
    end
    check("stream_cnt", fetch_cnt, 32'd4);

    // Decode stalls for 5 cycles: instruction held, no new request.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_en",    ram_en,      32'd0);
      check("stall_instr", instr,       32'hA0A0_0003);
      check("stall_valid", instr_valid, 32'd1);
    end
    instr_ready = 1'b1;
    tick();
    check("unstall_en",   ram_en, 32'd1);
    check("unstall_addr", addr,   32'd4);

    // Redirect during RESP: the in-flight word is discarded.
    tick();
    br_taken  = 1'b1;
    br_target = 32'd100;
    tick();
    br_taken = 1'b0;
    check("brresp_instr", instr,       32'hA0A0_0003);
    check("brresp_valid", instr_valid, 32'd0);
    check("brresp_cnt",   fetch_cnt,   32'd4);
    check("brresp_en",    ram_en,      32'd1);
    check("brresp_addr",  addr,        32'd100);
    tick();
    tick();
    check("br_instr", instr,     32'hA0A0_0064);
    check("br_ipc",   instr_pc,  32'd100);
    check("br_cnt",   fetch_cnt, 32'd5);

    // Redirect coinciding with a handshake in HOLD: redirect wins.
    br_taken  = 1'b1;
    br_target = 32'd200;
    tick();
    br_taken = 1'b0;
    check("brhs_valid", instr_valid, 32'd0);
    check("brhs_addr",  addr,        32'd200);
    check("brhs_cnt",   fetch_cnt,   32'd5);

    // ENABLE dropped mid-fetch does not abort; sampled on HOLD exit.
    tick();
    enable = 1'b0;
    tick();
    check("noab_ipc",   instr_pc,    32'd200);
    check("noab_valid", instr_valid, 32'd1);
    tick();
    check("idle_en",    ram_en,      32'd0);
    check("idle_valid", instr_valid, 32'd0);
    check("idle_addr",  addr,        32'd201);
    tick();
    check("idle2_en", ram_en, 32'd0);

    // Asynchronous reset asserted between edges while in RESP.
    enable = 1'b1;
    tick();
    check("pre_rst_addr", addr, 32'd201);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_addr",  addr,        32'd0);
    check("arst_en",    ram_en,      32'd0);
    check("arst_instr", instr,       32'd0);
    check("arst_ipc",   instr_pc,    32'd0);
    check("arst_valid", instr_valid, 32'd0);
    check("arst_cnt",   fetch_cnt,   32'd0);
    tick();
    check("arst_nocap",   instr,       32'd0);
    check("arst_novalid", instr_valid, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_en",   ram_en, 32'd1);
    check("post_rst_addr", addr,   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'd0, PC value loaded at reset (word address).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 Port: ENABLE  input  1  fetch permitted when 1.
REQ-005 Port: ADDR  output  32  word address to instruction memory.
REQ-006 Port: RW  output  2  memory access mode; constant 2'b01 (read).
REQ-007 Port: RAM_EN  output  1  memory request strobe.
REQ-008 Port: FETCH  input  32  instruction word from memory, valid the cycle after RAM_EN=1.
REQ-009 Port: INSTR  output  32  held instruction to decode.
REQ-010 Port: INSTR_PC  output  32  word address of INSTR.
REQ-011 Port: INSTR_VALID  output  1  INSTR/INSTR_PC valid.
REQ-012 Port: INSTR_READY  input  1  decode accepts; transfer when INSTR_VALID&INSTR_READY at rising edge.
REQ-013 Port: BR_TAKEN  input  1  redirect request.
REQ-014 Port: BR_TARGET  input  32  redirect word address.
REQ-015 Port: FETCH_CNT  output  16  count of instructions delivered to INSTR.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP, HOLD; one outstanding memory request maximum.
REQ-017 IDLE: RAM_EN=0; next=REQ if ENABLE=1, else IDLE.
REQ-018 REQ: RAM_EN=1, ADDR=PC; next=RESP unconditionally.
REQ-019 RESP: RAM_EN=0; at edge INSTR<=FETCH, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+1, FETCH_CNT<=FETCH_CNT+1; next=HOLD.
REQ-020 HOLD: INSTR_VALID=1, INSTR/INSTR_PC stable; on handshake INSTR_VALID<=0 and next=REQ if ENABLE=1 else IDLE; without handshake stay HOLD.
REQ-021 ADDR SHALL equal PC in all states; RAM_EN=1 only in REQ.
REQ-022 Throughput: one instruction per 3 cycles when INSTR_READY held 1 (REQ, RESP, HOLD).
REQ-023 PC+1 SHALL wrap 32'hFFFFFFFF -> 0; FETCH_CNT wraps 16'hFFFF -> 0.
REQ-024 BR_TAKEN=1 in any state SHALL at edge: PC<=BR_TARGET, INSTR_VALID<=0, discard any in-flight FETCH (no INSTR/FETCH_CNT update), next=REQ if ENABLE=1 else IDLE.
REQ-025 BR_TAKEN SHALL take priority over a simultaneous handshake and over RESP capture; the instruction in HOLD is dropped, not counted as transferred.
REQ-026 ENABLE=0 SHALL not abort REQ/RESP/HOLD; it is sampled only in IDLE and on HOLD exit.
REQ-027 INSTR_VALID SHALL never drop without handshake or BR_TAKEN.

Reset
REQ-028 RST_N=0 SHALL immediately force: state=IDLE, PC=RESET_PC, ADDR=RESET_PC, RAM_EN=0, RW=2'b01, INSTR=0, INSTR_PC=0, INSTR_VALID=0, FETCH_CNT=0.
REQ-029 Reset asserted mid-operation (any state) SHALL discard in-flight request; first REQ after release occurs the edge after ENABLE=1 is sampled in IDLE.

Verification
REQ-030 Reset release, ENABLE=1, INSTR_READY=1, memory words 0..3 = A0..A3 -> RAM_EN pulses at ADDR 0,1,2,3 every 3 cycles; INSTR=A0..A3 with INSTR_PC=0..3; FETCH_CNT=4.
REQ-031 INSTR_READY=0 for 5 cycles after first INSTR_VALID -> INSTR=A0 held stable, no RAM_EN pulse; after READY=1 next request ADDR=1.
REQ-032 BR_TAKEN=1, BR_TARGET=32'd100 during RESP -> INSTR not updated, INSTR_VALID=0, next RAM_EN at ADDR=100, FETCH_CNT unchanged.
REQ-033 BR_TAKEN=1 with INSTR_VALID=1 and INSTR_READY=1 same edge -> INSTR_VALID=0, PC=BR_TARGET.
REQ-034 RESET_PC=32'hFFFFFFFF, two fetches -> INSTR_PC=32'hFFFFFFFF then 32'h0.
REQ-035 RST_N=0 asserted in RESP between edges -> outputs immediately at REQ-028 values; no capture on following edge.
